// File: rtl/axi_stream_frame_fifo.sv
// Elastic first-word-fall-through AXI4-Stream FIFO for a source that cannot stall.
// On overflow the rest of the frame is dropped and storage resyncs on the next TUSER beat.
module axi_stream_frame_fifo #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [DATA_W-1:0]        s_axis_video_TDATA,
  input  logic                     s_axis_video_TVALID,
  input  logic                     s_axis_video_TUSER,
  input  logic                     s_axis_video_TLAST,
  output logic [DATA_W-1:0]        m_axis_video_TDATA,
  output logic                     m_axis_video_TVALID,
  input  logic                     m_axis_video_TREADY,
  output logic                     m_axis_video_TUSER,
  output logic                     m_axis_video_TLAST,
  output logic [DATA_W/8-1:0]      m_axis_video_TKEEP,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         drop_count_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = DATA_W + 2;

  typedef enum logic [1:0] {WAIT_SOF, PASS, DROP} wr_state_e;

  wr_state_e         state_q, state_d;
  logic [WW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              out_valid_q;
  logic [WW-1:0]     out_word_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  logic              full, wr_en, drop_frame, rd_en;
  logic              ram_has_data, load_out, ram_wr;
  logic [WW-1:0]     in_word;

  assign in_word      = {s_axis_video_TUSER, s_axis_video_TLAST, s_axis_video_TDATA};
  // Space freed by this cycle's read is deliberately not visible to this cycle's write.
  assign full         = (level_q == LW'(DEPTH));
  assign rd_en        = out_valid_q & m_axis_video_TREADY;
  // Beats in RAM = level minus the one parked in the output register.
  assign ram_has_data = (level_q != LW'(out_valid_q));
  assign load_out     = ~out_valid_q | rd_en;
  // The bypass path is only legal when nothing older is waiting in RAM.
  assign ram_wr       = wr_en & (~load_out | ram_has_data);

  // NOTE: every output of this block gets a default before the case, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    drop_frame = 1'b0;
    if (s_axis_video_TVALID) begin
      case (state_q)
        PASS: begin
          if (full) begin
            drop_frame = 1'b1;
            state_d    = DROP;
          end else begin
            wr_en = 1'b1;
          end
        end
        default: begin
          if (s_axis_video_TUSER && !full) begin
            wr_en   = 1'b1;
            state_d = PASS;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= WAIT_SOF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= drop_frame;
      if (drop_frame && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      level_q <= level_q + LW'(wr_en) - LW'(rd_en);
      if (load_out) begin
        if (ram_has_data) begin
          out_word_q  <= mem[rd_ptr_q];
          out_valid_q <= 1'b1;
          rd_ptr_q    <= rd_ptr_q + AW'(1);
        end else if (wr_en) begin
          out_word_q  <= in_word;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (ram_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end

  // NOTE: the storage array is not reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (ram_wr) mem[wr_ptr_q] <= in_word;
  end

  assign m_axis_video_TDATA  = out_word_q[DATA_W-1:0];
  assign m_axis_video_TLAST  = out_word_q[DATA_W];
  assign m_axis_video_TUSER  = out_word_q[DATA_W+1];
  assign m_axis_video_TVALID = out_valid_q;
  assign m_axis_video_TKEEP  = {(DATA_W/8){out_valid_q}};
  assign overflow_o          = overflow_q;
  assign drop_count_o        = drop_cnt_q;
  assign level_o             = level_q;

endmodule

// File: tb/tb_axi_stream_frame_fifo.sv
// Bench for axi_stream_frame_fifo: queue-based reference model with a negedge scoreboard monitor.
module tb_axi_stream_frame_fifo;

  localparam int DATA_W = 48;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_user, m_last;
  logic              m_ready = 1'b1;
  logic [DATA_W/8-1:0] m_keep;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic [LW-1:0]     level;

  axi_stream_frame_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_axis_video_TDATA(s_data), .s_axis_video_TVALID(s_valid),
    .s_axis_video_TUSER(s_user), .s_axis_video_TLAST(s_last),
    .m_axis_video_TDATA(m_data), .m_axis_video_TVALID(m_valid),
    .m_axis_video_TREADY(m_ready), .m_axis_video_TUSER(m_user),
    .m_axis_video_TLAST(m_last), .m_axis_video_TKEEP(m_keep),
    .overflow_o(overflow), .drop_count_o(drop_count), .level_o(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just the list of accepted, not-yet-transferred beats.
  logic [DATA_W+1:0] ref_q[$];
  bit                synced = 0;     // inside a frame whose beats are being kept
  bit                exp_ovf = 0;
  int unsigned       exp_drops = 0;
  bit                live = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        check("tvalid", m_valid, ref_q.size() != 0);
        check("tkeep", m_keep, (ref_q.size() != 0) ? 6'h3f : 6'h00);
        check("level", level, ref_q.size());
        check("overflow", overflow, exp_ovf);
        check("drop_count", drop_count, exp_drops);
        if (ref_q.size() != 0) check("head_beat", {m_user, m_last, m_data}, ref_q[0]);
      end
      if (!reset_n) begin
        ref_q.delete();
        synced    = 0;
        exp_ovf   = 0;
        exp_drops = 0;
        live      = 1;
      end else if (live) begin
        bit full, xfer;
        full    = (ref_q.size() == DEPTH);
        xfer    = (ref_q.size() != 0) && m_ready;
        exp_ovf = 0;
        if (s_valid) begin
          if (synced) begin
            if (full) begin
              synced  = 0;
              exp_ovf = 1;
              if (exp_drops < (2**CNT_W - 1)) exp_drops++;
            end else begin
              ref_q.push_back({s_user, s_last, s_data});
            end
          end else if (s_user && !full) begin
            ref_q.push_back({s_user, s_last, s_data});
            synced = 1;
          end
        end
        if (xfer) void'(ref_q.pop_front());
      end
    end
  end

  task automatic beat(input bit v, input logic [DATA_W-1:0] d, input bit u, input bit l);
    s_valid = v; s_data = d; s_user = u; s_last = l;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, '0, 0, 0);
  endtask

  task automatic frame(input int lines, input int bpl, input int base);
    for (int i = 0; i < lines * bpl; i++)
      beat(1, DATA_W'(base + i), i == 0, (i % bpl) == bpl - 1);
  endtask

  task automatic do_reset();
    s_valid = 0;
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  int seq = 1000;
  int pos = 0;

  initial begin
    // Power-on reset
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    check("rst_tvalid", m_valid, 0);
    check("rst_tdata", m_data, 0);
    check("rst_tuser_tlast", {m_user, m_last}, 0);
    check("rst_level", level, 0);

    // Straight-through frame, 4 lines x 8 beats
    m_ready = 1;
    frame(4, 8, 0);
    idle(4);
    check("t1_drop_count", drop_count, 0);

    // Stream joins mid-frame: leading non-SOF beats are discarded
    do_reset();
    for (int i = 0; i < 5; i++) beat(1, DATA_W'(500 + i), 0, i == 4);
    frame(2, 8, 100);
    idle(4);

    // Overflow with a stalled sink
    m_ready = 0;
    frame(1, 20, 200);
    check("t3_level_full", level, DEPTH);
    check("t3_drop_count", drop_count, 1);
    m_ready = 1;
    idle(DEPTH + 4);
    frame(1, 8, 300);
    idle(4);

    // Random backpressure with sparse input
    for (int c = 0; c < 600; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        beat(1, DATA_W'(seq), pos == 0, (pos % 8) == 7);
        seq++;
        pos = (pos + 1) % 16;
      end else begin
        idle(1);
      end
    end
    m_ready = 1;
    idle(DEPTH + 8);

    // Write into a full FIFO in the same cycle as a transfer
    m_ready = 0;
    frame(1, DEPTH, 400);
    check("t5_level_full", level, DEPTH);
    m_ready = 1;
    beat(1, DATA_W'(400 + DEPTH), 0, 0);
    check("t5_overflow", overflow, 1);
    check("t5_level", level, DEPTH - 1);

    // Reset while full in mid-frame
    m_ready = 0;
    beat(1, DATA_W'(600), 1, 0);
    beat(1, DATA_W'(601), 0, 0);
    beat(1, DATA_W'(602), 0, 0);
    check("t6_level_full", level, DEPTH);
    do_reset();
    check("t6_tvalid", m_valid, 0);
    check("t6_level", level, 0);
    check("t6_drop_count", drop_count, 0);
    m_ready = 1;
    for (int i = 0; i < 3; i++) beat(1, DATA_W'(700 + i), 0, 0);
    frame(1, 8, 800);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
